// File: rtl/dlfloat_dot_seq.sv
// Dot-product sequencer for the shared DLFloat16 MAC: clears the accumulator,
// streams N operand pairs, waits for the pipeline to drain and holds the result.
module dlfloat_dot_seq #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [15:0]      mac_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_sat,
  output logic             busy,
  output logic [LEN_W-1:0] cnt
);

  localparam int unsigned DW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [15:0]      mac_a_q, mac_a_d;
  logic [15:0]      mac_b_q, mac_b_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_clr_q, mac_clr_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic             hs;

  assign in_ready  = (state_q == S_STREAM);
  assign busy      = (state_q != S_IDLE);
  assign hs        = in_valid & in_ready;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign cnt       = cnt_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_en_d    = 1'b0;
    mac_clr_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (abort) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_d = '0;
            if (cfg_len != '0) begin
              len_d     = cfg_len;
              mac_clr_d = 1'b1;
              state_d   = S_CLEAR;
            end else begin
              out_data_d  = '0;
              out_sat_d   = 1'b0;
              out_valid_d = 1'b1;
              state_d     = S_HOLD;
            end
          end
        end
        S_CLEAR: state_d = S_STREAM;
        S_STREAM: begin
          if (hs) begin
            mac_a_d  = in_a;
            mac_b_d  = in_b;
            mac_en_d = 1'b1;
            cnt_d    = cnt_q + LEN_W'(1);
            if (cnt_d == len_q) begin
              drain_d = DW'(LAT);
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // LAT is counted from the cycle the final pair sits on mac_a/mac_b,
          // so the countdown holds while that pair is still presented.
          if (!mac_en_q) begin
            if (drain_q == '0) begin
              out_data_d  = mac_acc;
              out_sat_d   = (mac_acc == 16'hFFFF);
              out_valid_d = 1'b1;
              state_d     = S_HOLD;
            end else begin
              drain_d = drain_q - DW'(1);
            end
          end
        end
        S_HOLD: begin
          out_valid_d = 1'b1;
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// Directed bench for dlfloat_dot_seq with a behavioural LAT=2 DLFloat16 MAC
// (positive normal values only, enough for the hand-computed vectors).
module tb_dlfloat_dot_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [15:0] mac_a, mac_b, mac_acc, out_data;
  logic        mac_en, mac_clr, out_valid, out_sat, busy;
  logic        out_ready = 1'b0;
  logic [7:0]  cnt;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  dlfloat_dot_seq #(.LAT(2), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_acc(mac_acc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy), .cnt(cnt)
  );

  function automatic real dec(input logic [15:0] x);
    real v;
    int  e;
    v = 1.0 + real'(x[8:0]) / 512.0;
    e = int'(x[14:9]) - 31;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return v;
  endfunction

  function automatic logic [15:0] enc(input real v);
    int          e;
    logic [15:0] r;
    if (v == 0.0) return 16'h0000;
    e = 31;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    r = {1'b0, 6'(e), 9'($rtoi((v - 1.0) * 512.0))};
    return r;
  endfunction

  // Behavioural MAC: product registered on the presenting edge, accumulated next edge.
  real  acc = 0.0;
  real  prod_q = 0.0;
  logic prod_v = 1'b0;
  logic force_sat = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 0.0; prod_q <= 0.0; prod_v <= 1'b0;
    end else if (mac_clr) begin
      acc <= 0.0; prod_v <= 1'b0;
    end else begin
      if (prod_v) acc <= acc + prod_q;
      prod_v <= mac_en;
      prod_q <= mac_en ? dec(mac_a) * dec(mac_b) : 0.0;
    end
  end
  assign mac_acc = force_sat ? 16'hFFFF : enc(acc);

  int   en_count = 0;
  int   clr_count = 0;
  logic ov_seen = 1'b0;
  always @(negedge clk) begin
    if (mac_en) en_count++;
    if (mac_clr) clr_count++;
    if (out_valid) ov_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a command and leave the DUT in CLEAR (or HOLD for len 0).
  task automatic issue(input logic [7:0] len);
    start = 1'b1; cfg_len = len;
    tick();
    start = 1'b0; cfg_len = 8'hAA;
  endtask

  task automatic wait_ov(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({mac_a, mac_b, mac_en, mac_clr, in_ready, out_valid, out_data, out_sat, cnt, busy} !== '0) begin
      $display("FAIL reset_outputs: got a=%h b=%h en=%b clr=%b rdy=%b ov=%b d=%h sat=%b cnt=%0d busy=%b, want all 0",
               mac_a, mac_b, mac_en, mac_clr, in_ready, out_valid, out_data, out_sat, cnt, busy);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    en_count = 0; clr_count = 0;
    out_ready = 1'b1;
    issue(8'd3);
    total++;
    if (mac_clr !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL b2b_clr: mac_clr=%b busy=%b, want 1 1", mac_clr, busy);
    end else pass_cnt++;
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h4000;
    tick();
    total++;
    if (in_ready !== 1'b1 || mac_clr !== 1'b0) begin
      $display("FAIL b2b_stream_entry: in_ready=%b mac_clr=%b, want 1 0", in_ready, mac_clr);
    end else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (mac_en !== 1'b1 || mac_a !== 16'h3E00 || mac_b !== 16'h4000) begin
        $display("FAIL b2b_pair%0d: en=%b a=%h b=%h, want 1 3e00 4000", i, mac_en, mac_a, mac_b);
      end else pass_cnt++;
    end
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      $display("FAIL b2b_ready_drop: in_ready=%b, want 0", in_ready);
    end else pass_cnt++;
    wait_ov(n);
    total++;
    if (n !== 4) begin
      $display("FAIL b2b_latency: out_valid after %0d edges, want 4", n);
    end else pass_cnt++;
    total++;
    if (out_data !== 16'h4300 || out_sat !== 1'b0 || cnt !== 8'd3) begin
      $display("FAIL b2b_result: data=%h sat=%b cnt=%0d, want 4300 0 3", out_data, out_sat, cnt);
    end else pass_cnt++;
    tick();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || en_count !== 3 || clr_count !== 1) begin
      $display("FAIL b2b_done: busy=%b ov=%b en_cycles=%0d clr_cycles=%0d, want 0 0 3 1",
               busy, out_valid, en_count, clr_count);
    end else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    issue(8'd1);
    tick();
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3E00;
    tick();
    in_valid = 1'b0;
    wait_ov(n);
    total++;
    if (n < 0) begin
      $display("FAIL bp_timeout: out_valid never rose, want within 20 edges");
    end else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h3E00) begin
        $display("FAIL bp_hold%0d: ov=%b data=%h, want 1 3e00", i, out_valid, out_data);
      end else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL bp_release: busy=%b ov=%b, want 0 0", busy, out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_gapped();
    int   n;
    logic [5:0] pat;
    pat = 6'b101001;
    en_count = 0;
    issue(8'd3);
    tick();
    in_a = 16'h3E00; in_b = 16'h4000;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      tick();
      total++;
      if (mac_en !== pat[i] || (!pat[i] && mac_a !== 16'h0000)) begin
        $display("FAIL gap_cycle%0d: en=%b a=%h, want en=%b", i, mac_en, mac_a, pat[i]);
      end else pass_cnt++;
    end
    in_valid = 1'b0;
    wait_ov(n);
    total++;
    if (n !== 4 || out_data !== 16'h4300 || cnt !== 8'd3 || en_count !== 3) begin
      $display("FAIL gap_result: lat=%0d data=%h cnt=%0d en_cycles=%0d, want 4 4300 3 3",
               n, out_data, cnt, en_count);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_zero_len();
    en_count = 0; clr_count = 0;
    out_ready = 1'b0;
    issue(8'd0);
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
      $display("FAIL zero_hold: busy=%b ov=%b data=%h sat=%b, want 1 1 0000 0", busy, out_valid, out_data, out_sat);
    end else pass_cnt++;
    out_ready = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || en_count !== 0 || clr_count !== 0) begin
      $display("FAIL zero_quiet: busy=%b en_cycles=%0d clr_cycles=%0d, want 0 0 0", busy, en_count, clr_count);
    end else pass_cnt++;
  endtask

  task automatic test_abort();
    int n;
    start = 1'b1; abort = 1'b1; cfg_len = 8'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL abort_start_same: busy=%b, want 0", busy);
    end else pass_cnt++;
    issue(8'd4);
    tick();
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h4000;
    tick();
    tick();
    in_valid = 1'b0;
    ov_seen = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mac_en !== 1'b0 || cnt !== 8'd2) begin
      $display("FAIL abort_idle: busy=%b rdy=%b en=%b cnt=%0d, want 0 0 0 2", busy, in_ready, mac_en, cnt);
    end else pass_cnt++;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (ov_seen !== 1'b0) begin
      $display("FAIL abort_no_result: out_valid seen=%b, want 0", ov_seen);
    end else pass_cnt++;
    clr_count = 0;
    issue(8'd1);
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ov(n);
    total++;
    if (n !== 4 || out_data !== 16'h4000 || clr_count !== 1 || cnt !== 8'd1) begin
      $display("FAIL abort_rerun: lat=%0d data=%h clr_cycles=%0d cnt=%0d, want 4 4000 1 1",
               n, out_data, clr_count, cnt);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_saturation();
    int n;
    force_sat = 1'b1;
    issue(8'd2);
    tick();
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h4000;
    tick();
    tick();
    in_valid = 1'b0;
    wait_ov(n);
    total++;
    if (out_data !== 16'hFFFF || out_sat !== 1'b1) begin
      $display("FAIL sat_result: data=%h sat=%b, want ffff 1", out_data, out_sat);
    end else pass_cnt++;
    tick();
    force_sat = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    issue(8'd1);
    tick();
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3E00;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mac_a, mac_b, mac_en, mac_clr, in_ready, out_valid, out_data, out_sat, cnt, busy} !== '0) begin
      $display("FAIL async_reset: a=%h en=%b ov=%b d=%h sat=%b cnt=%0d busy=%b, want all 0",
               mac_a, mac_en, out_valid, out_data, out_sat, cnt, busy);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gapped();
    test_zero_len();
    test_abort();
    test_saturation();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/dlfloat_dot_seq.md
Name: dlfloat_dot_seq

Overview:
- Sequencer that runs a DLFloat16 dot product, sum of a_i*b_i for i=1..N, on the shared multiply-accumulate datapath.
- Accepts a start command carrying the vector length, clears the accumulator, then streams operand pairs into the MAC through a valid/ready handshake.
- After the last pair it waits for the MAC pipeline to drain, captures the accumulator and holds the result on a valid/ready output.
- Sits between the operand-loading logic and the MAC, replacing free-running pairwise loading.

Parameters:
LAT, 2, cycles from an operand pair being presented on mac_a/mac_b (mac_en=1) until mac_acc includes its product
LEN_W, 8, width of vector-length field and element counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  command pulse, sampled only in IDLE
cfg_len  in  LEN_W  number of operand pairs, sampled with start
abort  in  1  synchronous abort, any state
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer accepts pair
in_a  in  16  DLFloat16 operand a
in_b  in  16  DLFloat16 operand b
mac_a  out  16  operand a to MAC, registered
mac_b  out  16  operand b to MAC, registered
mac_en  out  1  mac_a/mac_b carry a real pair this cycle
mac_clr  out  1  synchronous accumulator clear, one-cycle pulse
mac_acc  in  16  current MAC accumulator value
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  16  captured dot-product result
out_sat  out  1  result saturated (out_data==16'hFFFF)
busy  out  1  state != IDLE
cnt  out  LEN_W  pairs accepted in current command

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0: mac_a, mac_b, mac_en, mac_clr, in_ready, out_valid, out_data, out_sat, cnt. Drain counter 0.
- All outputs are registered, except in_ready, which decodes state (1 only in STREAM) and busy.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, HOLD.
- IDLE:
  - start=1 with cfg_len!=0: latch len, cnt<=0, go to CLEAR.
  - start=1 with cfg_len==0: out_data<=16'h0000, out_sat<=0, go to HOLD (no MAC activity).
- CLEAR: mac_clr=1 for exactly this cycle, then STREAM.
- STREAM:
  - On handshake (in_valid & in_ready) at edge k: mac_a/mac_b<=in_a/in_b and mac_en<=1 for cycle k+1; cnt<=cnt+1.
  - Cycles without a handshake: mac_a=mac_b=16'h0000, mac_en=0. The MAC must ignore cycles with mac_en=0.
  - When the handshake makes cnt==len: load drain counter with LAT and go to DRAIN. in_ready is 0 from the next cycle.
- DRAIN:
  - Drain counter decrements each cycle.
  - In the cycle it reads 0: out_data<=mac_acc, out_sat<=(mac_acc==16'hFFFF), out_valid<=1, go to HOLD.
  - Hence out_valid rises LAT+2 edges after the final handshake edge.
- HOLD:
  - out_valid=1; out_data and out_sat stable.
  - On out_valid & out_ready: out_valid<=0, go to IDLE. A new start is honoured from the following cycle.
- start outside IDLE is ignored; cfg_len changes outside IDLE are ignored.
- abort=1 (highest priority after rst), from any state:
  - Next state IDLE.
  - out_valid<=0, mac_en<=0, mac_clr<=0, in_ready drops next cycle.
  - cnt retains its value for debug. No result is produced.
  - In IDLE, abort has no effect.
- abort and start in the same IDLE cycle: abort wins, start is dropped.
- A start pulse in the same cycle as out_ready in HOLD is ignored (state is not yet IDLE).
- cnt does not wrap: the maximum len is 2^LEN_W-1 and STREAM exits at equality.
- Mid-stream stalls (in_valid=0) are unbounded; the FSM waits in STREAM.
- Arithmetic is owned by the MAC. The sequencer only inspects mac_acc for 16'hFFFF saturation.

Test Plan:
- Bench uses a behavioural MAC model with LAT=2 for all scenarios.
- len=3, pairs (0x3E00,0x4000) x3 back-to-back, out_ready=1: mac_clr at start+1, three mac_en cycles, out_data=0x4300 (6.0), out_sat=0, out_valid exactly 4 edges after the third handshake.
- len=1, pair (0x3E00,0x3E00), out_ready held 0 for 5 cycles: out_valid and out_data=0x3E00 stable all 5 cycles, IDLE one edge after out_ready=1.
- len=3 with in_valid gapped (pair, 2 idle, pair, 1 idle, pair): mac_en=1 on exactly 3 cycles, mac_a=0 in the gaps, result 0x4300, cnt=3.
- cfg_len=0 start: HOLD next cycle, out_data=0x0000, no mac_clr and no mac_en pulse.
- Abort after 2 of 4 pairs: IDLE next cycle, out_valid never asserted, cnt=2. A following len=1 command runs normally with a fresh mac_clr.
- Saturation: the model forces mac_acc=0xFFFF and len=2 completes, giving out_data=0xFFFF, out_sat=1. Separately, asserting rst mid-DRAIN zeroes all outputs immediately, without waiting for a clock edge.
